// File: rtl/div_8.sv
// rtl/div_8.sv - sequential restoring divider, one quotient bit per clock, MSB first
// Shares the activate/endop handshake with the ALU shift-and-add multiplier.
module div_8 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             activate,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic [WIDTH-1:0] quot,
   output logic [WIDTH-1:0] rem,
   output logic             endop,
   output logic             busy,
   output logic             div0
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             div0_q, div0_d;
   logic             endop_q, endop_d;
   logic             busy_q, busy_d;

   logic [WIDTH:0]   s;
   logic [WIDTH-1:0] t;
   logic             borrow;
   logic [WIDTH-1:0] r_next;
   logic [WIDTH-1:0] q_next;

   // When no borrow occurs S-D < D, so the low WIDTH bits of the difference are exact.
   always_comb begin
      s      = {r_q, q_q[WIDTH-1]};
      t      = s[WIDTH-1:0] - d_q;
      borrow = (s < {1'b0, d_q});
      r_next = borrow ? s[WIDTH-1:0] : t;
      q_next = {q_q[WIDTH-2:0], ~borrow};
   end

   always_comb begin
      state_d = state_q;
      d_d     = d_q;
      q_d     = q_q;
      r_d     = r_q;
      count_d = count_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      div0_d  = div0_q;
      endop_d = endop_q;
      busy_d  = busy_q;
      unique case (state_q)
         IDLE: begin
            if (activate) begin
               d_d     = in2;
               q_d     = in1;
               r_d     = '0;
               count_d = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            q_d     = q_next;
            r_d     = r_next;
            count_d = count_q + 1'b1;
            if (count_q == CW'(WIDTH - 1)) begin
               quot_d  = q_next;
               rem_d   = r_next;
               div0_d  = (d_q == '0);
               endop_d = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            endop_d = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         d_q     <= '0;
         q_q     <= '0;
         r_q     <= '0;
         count_q <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         div0_q  <= 1'b0;
         endop_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         d_q     <= d_d;
         q_q     <= q_d;
         r_q     <= r_d;
         count_q <= count_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         div0_q  <= div0_d;
         endop_q <= endop_d;
         busy_q  <= busy_d;
      end
   end

   assign quot  = quot_q;
   assign rem   = rem_q;
   assign div0  = div0_q;
   assign endop = endop_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_div_8.sv
// tb/tb_div_8.sv - directed self-checking bench for div_8
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_div_8;

   logic       clk = 1'b0;
   logic       reset;
   logic       activate;
   logic [7:0] in1;
   logic [7:0] in2;
   logic [7:0] quot;
   logic [7:0] rem;
   logic       endop;
   logic       busy;
   logic       div0;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   div_8 #(.WIDTH(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .activate (activate),
      .in1      (in1),
      .in2      (in2),
      .quot     (quot),
      .rem      (rem),
      .endop    (endop),
      .busy     (busy),
      .div0     (div0)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er, input logic ed,
                        input string tag, input bit full);
      int n;
      @(negedge clk);
      activate = 1'b1;
      in1      = a;
      in2      = b;
      @(negedge clk);
      activate = 1'b0;
      in1      = 8'($urandom);
      in2      = 8'($urandom);
      if (full) check({tag, " busy"}, 32'(busy), 32'd1);
      n = 0;
      while (!endop && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, " latency"}, 32'(n), 32'd8);
      check({tag, " quot"}, 32'(quot), 32'(eq));
      check({tag, " rem"}, 32'(rem), 32'(er));
      check({tag, " div0"}, 32'(div0), 32'(ed));
      @(negedge clk);
      if (full) begin
         check({tag, " endop clear"}, 32'(endop), 32'd0);
         check({tag, " busy clear"}, 32'(busy), 32'd0);
         check({tag, " quot hold"}, 32'(quot), 32'(eq));
      end
   endtask

   initial begin
      bit         seen;
      bit         prev_busy;
      int         last_acc;
      int         done_cnt;
      logic [7:0] pa, pb, ea, eb;
      logic [7:0] qa[$];
      logic [7:0] qb[$];

      reset    = 1'b1;
      activate = 1'b0;
      in1      = '0;
      in2      = '0;
      repeat (2) @(negedge clk);
      check("reset quot", 32'(quot), 32'd0);
      check("reset rem", 32'(rem), 32'd0);
      check("reset endop", 32'(endop), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset div0", 32'(div0), 32'd0);
      reset = 1'b0;

      do_op(8'd200, 8'd7,   8'd28,  8'd4,  1'b0, "200/7",   1'b1);
      do_op(8'd255, 8'd1,   8'd255, 8'd0,  1'b0, "255/1",   1'b1);
      do_op(8'd255, 8'd255, 8'd1,   8'd0,  1'b0, "255/255", 1'b1);
      do_op(8'd5,   8'd10,  8'd0,   8'd5,  1'b0, "5/10",    1'b1);
      do_op(8'd0,   8'd3,   8'd0,   8'd0,  1'b0, "0/3",     1'b1);
      do_op(8'd77,  8'd0,   8'd255, 8'd77, 1'b1, "77/0",    1'b1);
      do_op(8'd9,   8'd3,   8'd3,   8'd0,  1'b0, "9/3",     1'b1);
      do_op(8'd200, 8'd7,   8'd28,  8'd4,  1'b0, "200/7b",  1'b1);

      // abort mid-operation; previous result (28 r 4) must be wiped
      @(negedge clk);
      activate = 1'b1;
      in1      = 8'd100;
      in2      = 8'd9;
      @(negedge clk);
      activate = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      check("abort quot", 32'(quot), 32'd0);
      check("abort rem", 32'(rem), 32'd0);
      check("abort busy", 32'(busy), 32'd0);
      check("abort endop", 32'(endop), 32'd0);
      check("abort div0", 32'(div0), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      seen  = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (endop || busy) seen = 1'b1;
      end
      check("abort no endop/busy", 32'(seen), 32'd0);
      do_op(8'd100, 8'd9, 8'd11, 8'd1, 1'b0, "100/9", 1'b1);

      // held activate with operands changing every cycle
      @(negedge clk);
      activate  = 1'b1;
      pa        = 8'($urandom);
      pb        = 8'($urandom);
      in1       = pa;
      in2       = pb;
      prev_busy = busy;
      last_acc  = -1;
      done_cnt  = 0;
      for (int c = 1; c <= 65; c++) begin
         @(negedge clk);
         if (busy && !prev_busy) begin
            qa.push_back(pa);
            qb.push_back(pb);
            if (last_acc >= 0) check("held spacing", 32'(c - last_acc), 32'd10);
            last_acc = c;
         end
         if (endop) begin
            done_cnt++;
            check("held busy with endop", 32'(busy), 32'd1);
            check("held latency", 32'(c - last_acc), 32'd8);
            if (qa.size() > 0) begin
               ea = qa.pop_front();
               eb = qb.pop_front();
               check("held quot", 32'(quot), (eb == 0) ? 32'd255 : 32'(ea / eb));
               check("held rem", 32'(rem), (eb == 0) ? 32'(ea) : 32'(ea % eb));
               check("held div0", 32'(div0), 32'(eb == 0));
            end else begin
               check("held result without accept", 32'd1, 32'd0);
            end
         end
         prev_busy = busy;
         pa  = 8'($urandom);
         pb  = 8'($urandom);
         in1 = pa;
         in2 = pb;
      end
      check("held completions", 32'(done_cnt), 32'd6);
      activate = 1'b0;
      repeat (12) @(negedge clk);

      // strided dividend sweep against every non-zero divisor
      for (int a = 0; a < 256; a += 17) begin
         for (int b = 1; b < 256; b++) begin
            do_op(8'(a), 8'(b), 8'(a / b), 8'(a % b), 1'b0, "sweep", 1'b0);
         end
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
